// File: rtl/clk_divider_16f_pkg.sv
// Shared constants for the 16f clock divider: counter width, wrap value
// and the count values at which each divided clock first reads high.
package clk_divider_16f_pkg;

  localparam int DIV_WIDTH = 4;

  typedef logic [DIV_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'(15);
  localparam cnt_t RISE_4F = cnt_t'(2);
  localparam cnt_t RISE_2F = cnt_t'(4);
  localparam cnt_t RISE_F  = cnt_t'(8);

  // True when the low 'bits' bits of cnt equal those of the rise point,
  // i.e. the divided clock of that period is entering its high phase.
  function automatic logic at_rise(input cnt_t cnt, input cnt_t point, input int bits);
    cnt_t mask;
    mask = cnt_t'((1 << bits) - 1);
    return (cnt & mask) == (point & mask);
  endfunction

endpackage

// File: rtl/clk_divider_16f.sv
// Divides clk16f by 2/4/8/16 from one free-running counter, with registered
// rise strobes, a synchronous phase-realign request and a lock flag.
module clk_divider_16f
  import clk_divider_16f_pkg::*;
(
  input  logic                 clk16f,
  input  logic                 reset_L,
  input  logic                 sync_req,
  output logic                 clk8f,
  output logic                 clk4f,
  output logic                 clk2f,
  output logic                 clkf,
  output logic                 rise_4f,
  output logic                 rise_2f,
  output logic                 rise_f,
  output logic [DIV_WIDTH-1:0] phase,
  output logic                 locked
);

  cnt_t cnt;
  cnt_t cnt_next;

  // NOTE: every always_comb output gets a value on all paths, so no latch is inferred.
  always_comb begin
    cnt_next = cnt + cnt_t'(1);
  end

  // Strobes are decoded from the next count so they are flops that go high
  // on the same edge as the divided clock they mark.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk16f) begin
    if (!reset_L || sync_req) begin
      cnt     <= '0;
      rise_4f <= 1'b0;
      rise_2f <= 1'b0;
      rise_f  <= 1'b0;
      locked  <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      rise_4f <= at_rise(cnt_next, RISE_4F, 2);
      rise_2f <= at_rise(cnt_next, RISE_2F, 3);
      rise_f  <= at_rise(cnt_next, RISE_F, 4);
      if (cnt == CNT_MAX)
        locked <= 1'b1;
    end
  end

  // Outputs are straight counter bits: no decode logic between flop and pin.
  assign clk8f = cnt[0];
  assign clk4f = cnt[1];
  assign clk2f = cnt[2];
  assign clkf  = cnt[3];
  assign phase = cnt;

endmodule

// File: tb/tb_clk_divider_16f.sv
// Self-checking bench for clk_divider_16f: directed reset/sync scenarios
// followed by random reset/sync traffic against an edge-count model.
module tb_clk_divider_16f;

  logic       clk16f;
  logic       reset_L;
  logic       sync_req;
  logic       clk8f, clk4f, clk2f, clkf;
  logic       rise_4f, rise_2f, rise_f;
  logic [3:0] phase;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int n_edges = 0;  // edges counted since last reset or sync

  clk_divider_16f dut (
    .clk16f  (clk16f),
    .reset_L (reset_L),
    .sync_req(sync_req),
    .clk8f   (clk8f),
    .clk4f   (clk4f),
    .clk2f   (clk2f),
    .clkf    (clkf),
    .rise_4f (rise_4f),
    .rise_2f (rise_2f),
    .rise_f  (rise_f),
    .phase   (phase),
    .locked  (locked)
  );

  initial clk16f = 1'b0;
  always #2 clk16f = ~clk16f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge_count=%0d got=%0h expected=%0h", tag, n_edges, got, exp);
    end
  endtask

  // Expected outputs come from the elapsed edge count alone: each divided
  // clock of period P is high in the second half of its period.
  task automatic check_outputs();
    int p;
    p = n_edges % 16;
    check("phase",   32'(phase),   32'(p));
    check("clk8f",   32'(clk8f),   32'((p % 2) >= 1));
    check("clk4f",   32'(clk4f),   32'((p % 4) >= 2));
    check("clk2f",   32'(clk2f),   32'((p % 8) >= 4));
    check("clkf",    32'(clkf),    32'(p >= 8));
    check("rise_4f", 32'(rise_4f), 32'((p % 4) == 2));
    check("rise_2f", 32'(rise_2f), 32'((p % 8) == 4));
    check("rise_f",  32'(rise_f),  32'(p == 8));
    check("locked",  32'(locked),  32'(n_edges >= 16));
  endtask

  task automatic step(input logic rst_n_in, input logic sync_in);
    @(negedge clk16f);
    reset_L  = rst_n_in;
    sync_req = sync_in;
    @(posedge clk16f);
    if (!rst_n_in || sync_in) n_edges = 0;
    else                      n_edges++;
    #1;
    check_outputs();
  endtask

  initial begin
    reset_L  = 1'b0;
    sync_req = 1'b0;

    // Reset for two edges, then free-run 75 edges for period and lock checks.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 75; i++) step(1'b1, 1'b0);
    check("phase_before_sync", 32'(phase), 32'd11);

    // One-edge sync pulse at phase 11, then watch lock re-assert.
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    check("phase_before_rst_sync", 32'(phase), 32'd7);

    // Reset and sync together at phase 7, then release.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

    // Sync held for several edges, mid-period reset, then resume.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0);

    // Random traffic with occasional resets and sync requests.
    for (int i = 0; i < 800; i++) begin
      logic r, s;
      r = ($urandom_range(0, 59) != 0);
      s = ($urandom_range(0, 29) == 0);
      step(r, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_divider_16f.md
CLK_DIVIDER_16F -- requirements
Module: clk_divider_16f

Interface
REQ-001 SHALL: clk16f  input  1  master clock (16f); all flops on its rising edge; no other clock.
REQ-002 SHALL: reset_L  input  1  synchronous, active-low reset sampled on clk16f rising edge.
REQ-003 SHALL: sync_req  input  1  phase realign request, sampled on clk16f.
REQ-004 SHALL: clk8f  output  1  clk16f / 2, 50% duty.
REQ-005 SHALL: clk4f  output  1  clk16f / 4, 50% duty.
REQ-006 SHALL: clk2f  output  1  clk16f / 8, 50% duty.
REQ-007 SHALL: clkf  output  1  clk16f / 16, 50% duty.
REQ-008 SHALL: rise_4f, rise_2f, rise_f  output  1 each  one-clk16f-cycle strobe, high in the cycle the matching clock first reads high.
REQ-009 SHALL: phase  output  4  current divider count, 0..15.
REQ-010 SHALL: locked  output  1  high once a full clkf period has elapsed since reset or last sync.

Function
REQ-011 SHALL: hold a 4-bit counter cnt; per clk16f edge cnt <= cnt+1 mod 16 (15 wraps to 0, no saturation).
REQ-012 SHALL: drive clk8f=cnt[0], clk4f=cnt[1], clk2f=cnt[2], clkf=cnt[3], phase=cnt; all from flops, no combinational decode to outputs (glitch-free).
REQ-013 SHALL: assert rise_4f exactly when cnt[1:0]==2, rise_2f when cnt[2:0]==4, rise_f when cnt==8; registered, aligned with the clock edge they mark.
REQ-014 SHALL: sync_req high at an edge -> cnt=0, all divided clocks and strobes 0, locked=0 at that edge; counting resumes at the next edge with sync_req low.
REQ-015 SHALL: sync_req held high -> cnt held at 0, outputs held low, locked held 0.
REQ-016 SHALL: set locked on the edge where cnt goes 15->0 without sync_req; stays high until reset or sync_req.
REQ-017 SHALL: latency: first edge after reset release gives cnt=1 (clk8f=1); clkf first rises 8 edges after release; locked first high 16 edges after release.
REQ-018 SHALL: reset_L low and sync_req high together -> reset behaviour (identical result, reset has priority).

Reset
REQ-019 SHALL: reset_L low at an edge -> cnt=0, clk8f/clk4f/clk2f/clkf=0, all rise_* =0, phase=0, locked=0.
REQ-020 SHALL: reset mid-period aborts current phase immediately; no partial pulse or strobe after the reset edge.
REQ-021 SHALL: no asynchronous reset path; outputs are X-free from the first edge with reset_L low.

Structure
REQ-022 SHALL: shared package holds DIV_WIDTH=4, CNT_MAX=15, and rise-point constants (RISE_4F=2, RISE_2F=4, RISE_F=8).
REQ-023 SHALL: single module, no sub-module; counter, decode flops and lock flag in one block.
REQ-024 SHALL: synthesizable, no delays; the existing prober (clk16f half-period 2 time units, reset_L from flop) drives it unchanged.

Verification
REQ-025 SHALL: reset_L=0 two edges, release -> all outputs 0 during reset; edge 1 after release clk8f=1, phase=1.
REQ-026 SHALL: free-run 64 edges -> clk8f/clk4f/clk2f/clkf periods 2/4/8/16 edges, 50% duty, clkf rising edges are 16 edges apart.
REQ-027 SHALL: free-run -> rise_f high only at phase=8, rise_2f at phase 4 and 12, rise_4f at phase 2,6,10,14; each exactly one edge wide.
REQ-028 SHALL: pulse sync_req one edge at phase=11 -> phase=0, locked=0 that edge; phase=1 next edge; locked re-asserts 16 edges after sync.
REQ-029 SHALL: reset_L=0 and sync_req=1 same edge at phase=7 -> all outputs 0; release -> sequence matches REQ-025.
REQ-030 SHALL: locked check -> 0 for edges 1..15 after release, 1 from edge 16 through 75 edges with no sync/reset.
